cello_lut_engine: RTL and testbench
===================================

Name: cello_lut_engine

Overview:
- Runtime-programmable N-input truth-table gate: generalised successor of the fixed 3-input truth-table modules in the Cello gate library.
- Holds the truth table in an active register, reloadable through a serial config port with atomic commit.
- Evaluates input vectors through a valid/ready handshake into a 2-entry output FIFO.
- Used as a drop-in reconfigurable gate model for circuit simulation and hardware-in-loop test of candidate logic functions.

Parameters:
- N_IN, 3, number of logic inputs (1..6); table width TW = 2**N_IN.
- TT_INIT, 8'h83, truth table loaded at reset, TW bits; MSB = output for all-zero input vector.
- CNT_W, 16, width of saturating evaluation counter.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  config bit present.
- cfg_ready  out  1  config bit can be accepted.
- cfg_bit  in  1  table bit, shifted MSB first.
- cfg_last  in  1  marks final bit of a table load.
- cfg_err  out  1  one-cycle pulse: malformed load discarded.
- in_valid  in  1  input vector present.
- in_ready  out  1  engine accepts vector.
- in_vec  in  N_IN  inputs; in_vec[N_IN-1] is in1 (MSB of index).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_bit  out  1  gate output for head-of-FIFO.
- tt_active  out  TW  currently committed table.
- eval_cnt  out  CNT_W  accepted evaluations, saturating.

Behaviour:
- Reset (async, rst_n=0): tt_active=TT_INIT, shadow=0, bit counter=0, state=IDLE, FIFO empty, out_valid=0, out_bit=0, cfg_err=0, eval_cnt=0. Reset mid-load discards the partial load. Reset with results queued flushes the FIFO.
- Lookup: idx = in_vec as unsigned; result = tt_active[TW-1-idx]. Example: TT 8'h83 gives 1 for idx 0, 6, 7 and 0 otherwise.
- State machine: IDLE, LOAD, COMMIT.
  - IDLE: a cfg accept (cfg_valid & cfg_ready) shifts cfg_bit into shadow, sets count=1, and moves to LOAD. The same rules apply when TW=1.
  - LOAD: each cfg accept shifts in one bit (shadow <= {shadow[TW-2:0], cfg_bit}) and increments count.
  - cfg_last on the accept with count==TW-1 (the TW-th bit) goes to COMMIT.
  - cfg_last on an earlier bit, or the TW-th bit without cfg_last: pulse cfg_err for 1 cycle, clear shadow and count, return to IDLE, tt_active unchanged.
  - COMMIT (exactly 1 cycle): tt_active <= shadow, return to IDLE.
  - cfg_ready = (state != COMMIT).
- Evaluation acceptance:
  - in_ready = (state==IDLE) & !cfg_valid & (FIFO count < 2).
  - Config has priority: no vector is accepted during LOAD/COMMIT or in a cycle where cfg_valid=1 in IDLE.
  - On accept, the result is computed from tt_active of that cycle and pushed. Queued results keep the table they were evaluated with; a commit never alters them.
  - Latency: vector accepted at edge k gives out_valid=1 after edge k (1 cycle).
- FIFO:
  - 2 entries; out_valid = count > 0; out_bit = head entry, 0 when empty.
  - Pop on out_valid & out_ready.
  - Simultaneous push and pop with count==1: count stays 1, new result becomes head next cycle.
  - At count==2, in_ready=0; in_ready never depends combinationally on out_ready.
- eval_cnt increments on every in accept and saturates at 2**CNT_W-1.

Test Plan:
- Reset, then drive in_vec 0..7 (out_ready=1) -> out_bit sequence 1,0,0,0,0,0,1,1; out_valid 1 cycle after each accept; eval_cnt=8.
- Load 8 bits of 8'h96 MSB first, cfg_last on bit 8 -> cfg_err stays 0; tt_active=8'h96 one cycle after the last accept; in_ready=0 throughout load and commit; vectors 0..7 then give 1,0,0,1,0,1,1,0.
- cfg_last on bit 5 -> cfg_err pulses once; tt_active stays 8'h83; state returns to IDLE; a following correct load succeeds.
- out_ready=0 with 3 vectors offered -> 2 accepted, then in_ready=0; raise out_ready -> results drain in order and the third vector is accepted.
- Queue 2 results under 8'h83, then load and commit 8'h00 -> both queued results match 8'h83 values; subsequent results are 0.
- Assert rst_n low after 4 config bits with a full FIFO -> out_valid=0 immediately; tt_active=8'h83; the next load starts from count 0.

Source files
------------

// File: rtl/cello_lut_engine.sv
// Runtime-programmable N-input truth-table gate: serial table reload with atomic
// commit, handshake-driven evaluation into a 2-entry result FIFO.
module cello_lut_engine #(
  parameter int                    N_IN    = 3,
  parameter logic [(2**N_IN)-1:0]  TT_INIT = 8'h83,
  parameter int                    CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic                 cfg_bit,
  input  logic                 cfg_last,
  output logic                 cfg_err,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN-1:0]      in_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_bit,
  output logic [(2**N_IN)-1:0] tt_active,
  output logic [CNT_W-1:0]     eval_cnt,
  output logic [1:0]           fsm_state
);

  localparam int TW = 2**N_IN;
  localparam int BW = $clog2(TW + 1);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; valid never waits on ready, and ready never depends on the same
  // channel's valid (in_ready does see cfg_valid, because config wins).

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [TW-1:0] shadow, shadow_next;
  logic [BW-1:0] bit_cnt, bit_cnt_next;
  logic          err_next;
  logic          cfg_acc;
  logic [TW:0]   shifted;

  assign fsm_state = state;
  assign cfg_ready = (state != COMMIT);
  assign cfg_acc   = cfg_valid & cfg_ready;
  assign shifted   = {shadow, cfg_bit};

  always_comb begin
    state_next   = state;
    shadow_next  = shadow;
    bit_cnt_next = bit_cnt;
    err_next     = 1'b0;
    case (state)
      IDLE, LOAD: begin
        if (cfg_acc) begin
          if ((bit_cnt == BW'(TW - 1)) && cfg_last) begin
            shadow_next  = shifted[TW-1:0];
            bit_cnt_next = '0;
            state_next   = COMMIT;
          end else if ((bit_cnt == BW'(TW - 1)) || cfg_last) begin
            // Early cfg_last or a missing one: drop the whole partial load.
            err_next     = 1'b1;
            shadow_next  = '0;
            bit_cnt_next = '0;
            state_next   = IDLE;
          end else begin
            shadow_next  = shifted[TW-1:0];
            bit_cnt_next = bit_cnt + BW'(1);
            state_next   = LOAD;
          end
        end
      end
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shadow    <= '0;
      bit_cnt   <= '0;
      cfg_err   <= 1'b0;
      tt_active <= TT_INIT;
    end else begin
      state   <= state_next;
      shadow  <= shadow_next;
      bit_cnt <= bit_cnt_next;
      cfg_err <= err_next;
      if (state == COMMIT) tt_active <= shadow;
    end
  end

  // Evaluation path and result FIFO
  logic [1:0]      fifo_mem;
  logic            rd_ptr, wr_ptr;
  logic [1:0]      fifo_cnt;
  logic            push, pop;
  logic [N_IN-1:0] sel;
  logic            lookup;

  // Table MSB belongs to index 0, so the bit position is TW-1-idx, i.e. ~idx.
  assign sel       = ~in_vec;
  assign lookup    = tt_active[sel];
  assign in_ready  = (state == IDLE) & ~cfg_valid & (fifo_cnt < 2'd2);
  assign out_valid = (fifo_cnt != 2'd0);
  assign out_bit   = out_valid & fifo_mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mem <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      fifo_cnt <= '0;
      eval_cnt <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= lookup;
        wr_ptr           <= ~wr_ptr;
        if (eval_cnt != {CNT_W{1'b1}}) eval_cnt <= eval_cnt + CNT_W'(1);
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_cello_lut_engine.sv
// Directed bench for cello_lut_engine: table-driven lookups plus hand-written
// config, back-pressure, commit-ordering and reset sequences.
module tb_cello_lut_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid, cfg_ready, cfg_bit, cfg_last, cfg_err;
  logic        in_valid, in_ready;
  logic [2:0]  in_vec;
  logic        out_valid, out_ready, out_bit;
  logic [7:0]  tt_active;
  logic [15:0] eval_cnt;
  logic [1:0]  fsm_state;

  int errors = 0;
  int checks = 0;
  int exp_evals = 0;
  logic [0:0] exp_q[$];

  typedef struct packed {
    logic [2:0] vec;
    logic       exp_bit;
  } vec_t;
  vec_t tbl_83[8];
  vec_t tbl_96[8];

  cello_lut_engine dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_bit(cfg_bit),
    .cfg_last(cfg_last), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .tt_active(tt_active), .eval_cnt(eval_cnt), .fsm_state(fsm_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted vector with out_ready=1: result visible one edge later.
  task automatic apply_vec(input logic [2:0] v, input logic e);
    in_valid = 1'b1;
    in_vec   = v;
    #1 chk("in_ready_eval", in_ready, 1'b1);
    tick();
    exp_evals++;
    chk("out_valid_eval", out_valid, 1'b1);
    chk($sformatf("out_bit_vec%0d", v), out_bit, e);
  endtask

  // Serial load; ok=1 expects commit, ok=0 expects a cfg_err pulse.
  task automatic load_tt(input logic [7:0] tt, input int nbits, input logic last_final,
                         input logic ok, input logic [7:0] exp_tt);
    in_valid = 1'b1;
    in_vec   = 3'd5;
    for (int i = 0; i < nbits; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = tt[7-i];
      cfg_last  = last_final && (i == nbits - 1);
      #1;
      chk("cfg_ready_load", cfg_ready, 1'b1);
      chk("in_ready_load", in_ready, 1'b0);
      tick();
      if (i < nbits - 1) chk("cfg_err_mid", cfg_err, 1'b0);
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    in_valid  = 1'b0;
    if (ok) begin
      chk("state_commit", fsm_state, 2'd2);
      chk("cfg_ready_commit", cfg_ready, 1'b0);
      chk("in_ready_commit", in_ready, 1'b0);
      chk("cfg_err_ok", cfg_err, 1'b0);
      tick();
      chk("tt_after_commit", tt_active, tt);
      chk("state_idle_commit", fsm_state, 2'd0);
    end else begin
      chk("cfg_err_pulse", cfg_err, 1'b1);
      chk("state_idle_err", fsm_state, 2'd0);
      tick();
      chk("cfg_err_clear", cfg_err, 1'b0);
      chk("tt_after_err", tt_active, exp_tt);
    end
    chk("eval_cnt_load", eval_cnt, exp_evals);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 10 && exp_q.size() > 0; n++) begin
      if (out_valid) chk("drain_bit", out_bit, exp_q.pop_front());
      tick();
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    chk("drain_empty", out_valid, 1'b0);
  endtask

  initial begin
    tbl_83 = '{'{3'd0, 1'b1}, '{3'd1, 1'b0}, '{3'd2, 1'b0}, '{3'd3, 1'b0},
               '{3'd4, 1'b0}, '{3'd5, 1'b0}, '{3'd6, 1'b1}, '{3'd7, 1'b1}};
    tbl_96 = '{'{3'd0, 1'b1}, '{3'd1, 1'b0}, '{3'd2, 1'b0}, '{3'd3, 1'b1},
               '{3'd4, 1'b0}, '{3'd5, 1'b1}, '{3'd6, 1'b1}, '{3'd7, 1'b0}};

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0; cfg_last = 1'b0;
    in_valid = 1'b0; in_vec = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    chk("rst_tt", tt_active, 8'h83);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_bit", out_bit, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_eval_cnt", eval_cnt, 0);
    chk("rst_state", fsm_state, 2'd0);
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_in_ready", in_ready, 1'b1);

    // Default table, all indices
    for (int i = 0; i < 8; i++) apply_vec(tbl_83[i].vec, tbl_83[i].exp_bit);
    in_valid = 1'b0;
    tick();
    chk("out_valid_after_83", out_valid, 1'b0);
    chk("eval_cnt_8", eval_cnt, 8);

    // Malformed loads: early last on bit 5, then bit 8 without last
    load_tt(8'h96, 5, 1'b1, 1'b0, 8'h83);
    load_tt(8'h96, 8, 1'b0, 1'b0, 8'h83);
    load_tt(8'h96, 8, 1'b1, 1'b1, 8'h96);
    for (int i = 0; i < 8; i++) apply_vec(tbl_96[i].vec, tbl_96[i].exp_bit);
    in_valid = 1'b0;
    tick();
    chk("eval_cnt_16", eval_cnt, exp_evals);

    // Back-pressure: two accepted, third held until a slot frees
    load_tt(8'h83, 8, 1'b1, 1'b1, 8'h83);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_vec    = 3'd6;
    #1 chk("bp_ready0", in_ready, 1'b1);
    tick();
    chk("bp_valid0", out_valid, 1'b1);
    chk("bp_head0", out_bit, 1'b1);
    in_vec = 3'd1;
    #1 chk("bp_ready1", in_ready, 1'b1);
    tick();
    chk("bp_head_hold", out_bit, 1'b1);
    in_vec = 3'd7;
    #1 chk("bp_full", in_ready, 1'b0);
    tick();
    out_ready = 1'b1;
    #1 chk("bp_no_comb_ready", in_ready, 1'b0);
    chk("bp_pop_a", out_bit, 1'b1);
    tick();
    chk("bp_ready_after_pop", in_ready, 1'b1);
    chk("bp_pop_b", out_bit, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("bp_valid_c", out_valid, 1'b1);
    chk("bp_pop_c", out_bit, 1'b1);
    tick();
    chk("bp_empty", out_valid, 1'b0);
    exp_evals += 3;
    chk("bp_eval_cnt", eval_cnt, exp_evals);

    // Results queued under 8'h83 survive a commit of 8'h00
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_vec    = 3'd0;
    tick();
    exp_q.push_back(1'b1);
    in_vec = 3'd6;
    tick();
    exp_q.push_back(1'b1);
    in_valid = 1'b0;
    exp_evals += 2;
    load_tt(8'h00, 8, 1'b1, 1'b1, 8'h00);
    drain();
    apply_vec(3'd0, 1'b0);
    apply_vec(3'd6, 1'b0);
    in_valid = 1'b0;
    tick();

    // Async reset mid-load with a full FIFO
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_vec    = 3'd7;
    tick();
    tick();
    in_valid = 1'b0;
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_state", fsm_state, 2'd1);
    chk("pre_rst_full", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_bit", out_bit, 1'b0);
    chk("arst_tt", tt_active, 8'h83);
    chk("arst_eval_cnt", eval_cnt, 0);
    chk("arst_state", fsm_state, 2'd0);
    cfg_valid = 1'b0;
    exp_evals = 0;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    load_tt(8'h5a, 8, 1'b1, 1'b1, 8'h5a);
    apply_vec(3'd1, 1'b1);
    apply_vec(3'd7, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("final_eval_cnt", eval_cnt, exp_evals);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
